// File: rtl/vta_host_pkg.sv
// vta_host_pkg: register map, opcodes and sequencer states for the VTA host launch sequencer
package vta_host_pkg;
  localparam int CTRL_ADDR = 'h00;
  localparam int CYCLES_ADDR = 'h04;
  localparam int ARG_BASE = 'h08;
  localparam int ARG_STRIDE = 4;
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_DONE_BIT = 1;
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;
  typedef enum logic [3:0] {
    S_IDLE, S_WR_ARG, S_WR_START, S_RD_CTRL, S_WAIT_CTRL, S_GAP, S_RD_CYC, S_WAIT_CYC, S_DONE
  } state_t;
endpackage

// File: rtl/vta_host_req_port.sv
// vta_host_req_port: request register held until deq, plus tracking of the one outstanding read
module vta_host_req_port
  import vta_host_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 issue,
  input  logic                 abort,
  input  logic                 issue_op,
  input  logic [ADDR_BITS-1:0] issue_addr,
  input  logic [DATA_BITS-1:0] issue_value,
  input  logic                 req_deq,
  input  logic                 resp_valid,
  output logic                 req_valid,
  output logic                 req_opcode,
  output logic [ADDR_BITS-1:0] req_addr,
  output logic [DATA_BITS-1:0] req_value,
  output logic                 accepted,
  output logic                 resp_ok
);
  logic pending;
  assign accepted = req_valid && req_deq;
  // a response only counts once its read was accepted on an earlier edge
  assign resp_ok = resp_valid && pending;
  always_ff @(posedge clock)
    if (reset || abort) begin
      req_valid <= 1'b0;
      req_opcode <= 1'b0;
      req_addr <= '0;
      req_value <= '0;
      pending <= 1'b0;
    end else begin
      if (issue) begin
        req_valid <= 1'b1;
        req_opcode <= issue_op;
        req_addr <= issue_addr;
        req_value <= issue_value;
      end else if (accepted) req_valid <= 1'b0;
      if (accepted && req_opcode == OP_RD) pending <= 1'b1;
      else if (resp_ok) pending <= 1'b0;
    end
endmodule

// File: rtl/vta_host_launch_seq.sv
// vta_host_launch_seq: writes args, starts VTA, polls CTRL until done, then reads CYCLES.
// Define VTA_HOST_LAUNCH_SEQ_TIMEOUT_EN to add a busy-cycle watchdog that forces DONE with done_timeout.
module vta_host_launch_seq
  import vta_host_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 32,
  parameter int NUM_ARGS = 4,
  parameter int POLL_GAP = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [NUM_ARGS*DATA_BITS-1:0] cmd_args,
  output logic                          req_valid,
  output logic                          req_opcode,
  output logic [ADDR_BITS-1:0]          req_addr,
  output logic [DATA_BITS-1:0]          req_value,
  input  logic                          req_deq,
  input  logic                          resp_valid,
  input  logic [DATA_BITS-1:0]          resp_bits,
  output logic                          busy,
  output logic                          done_valid,
  output logic [DATA_BITS-1:0]          done_cycles,
  output logic                          done_timeout
);
  localparam int IW = $clog2(NUM_ARGS) + 1;
  localparam int GW = $clog2(POLL_GAP + 1);
  state_t state, nxt;
  logic [IW-1:0] arg_idx, idx_n;
  logic [NUM_ARGS*DATA_BITS-1:0] args_q;
  logic [GW-1:0] gap_cnt;
  logic issue, iss_op, accepted, resp_ok, abort, to_q, accept_cmd;
  logic [ADDR_BITS-1:0] iss_addr;
  logic [DATA_BITS-1:0] iss_value;
  assign cmd_ready = state == S_IDLE;
  assign busy = !cmd_ready;
  assign done_valid = state == S_DONE;
  assign done_timeout = done_valid && to_q;
  assign accept_cmd = cmd_valid && cmd_ready;
  assign idx_n = cmd_ready ? '0 : arg_idx + 1'b1;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:      nxt = cmd_valid ? S_WR_ARG : S_IDLE;
      S_WR_ARG:    nxt = !accepted ? S_WR_ARG : arg_idx == IW'(NUM_ARGS - 1) ? S_WR_START : S_WR_ARG;
      S_WR_START:  nxt = accepted ? S_RD_CTRL : S_WR_START;
      S_RD_CTRL:   nxt = accepted ? S_WAIT_CTRL : S_RD_CTRL;
      S_WAIT_CTRL: nxt = !resp_ok ? S_WAIT_CTRL : resp_bits[CTRL_DONE_BIT] ? S_RD_CYC : S_GAP;
      S_GAP:       nxt = gap_cnt == GW'(1) ? S_RD_CTRL : S_GAP;
      S_RD_CYC:    nxt = accepted ? S_WAIT_CYC : S_RD_CYC;
      S_WAIT_CYC:  nxt = resp_ok ? S_DONE : S_WAIT_CYC;
      default:     nxt = S_IDLE;
    endcase
    if (abort) nxt = S_DONE;
    // the next request is loaded on the same edge that retires the previous one
    issue = !abort && (nxt != state || (state == S_WR_ARG && accepted)) &&
            (nxt == S_WR_ARG || nxt == S_WR_START || nxt == S_RD_CTRL || nxt == S_RD_CYC);
    iss_op = (nxt == S_WR_ARG || nxt == S_WR_START) ? OP_WR : OP_RD;
    iss_addr = nxt == S_WR_ARG ? ADDR_BITS'(ARG_BASE + ARG_STRIDE * 32'(idx_n)) :
               nxt == S_RD_CYC ? ADDR_BITS'(CYCLES_ADDR) : ADDR_BITS'(CTRL_ADDR);
    iss_value = nxt == S_WR_ARG ? (cmd_ready ? cmd_args[DATA_BITS-1:0] : args_q[DATA_BITS-1:0]) :
                nxt == S_WR_START ? DATA_BITS'(1 << CTRL_START_BIT) : '0;
  end
  // args_q always holds the not-yet-issued args with the next one in the low word
  always_ff @(posedge clock)
    if (reset) begin
      state <= S_IDLE;
      arg_idx <= '0;
      args_q <= '0;
      gap_cnt <= '0;
      done_cycles <= '0;
      to_q <= 1'b0;
    end else begin
      state <= nxt;
      if (accept_cmd) begin
        arg_idx <= '0;
        args_q <= cmd_args >> DATA_BITS;
        to_q <= 1'b0;
      end else if (state == S_WR_ARG && accepted) begin
        arg_idx <= idx_n;
        args_q <= args_q >> DATA_BITS;
      end
      gap_cnt <= (state == S_WAIT_CTRL && resp_ok) ? GW'(POLL_GAP) : state == S_GAP ? gap_cnt - 1'b1 : gap_cnt;
      if (abort) begin
        done_cycles <= '0;
        to_q <= 1'b1;
      end else if (state == S_WAIT_CYC && resp_ok) done_cycles <= resp_bits;
    end
`ifdef VTA_HOST_LAUNCH_SEQ_TIMEOUT_EN
  logic [31:0] wd;
  always_ff @(posedge clock)
    if (reset || accept_cmd) wd <= '0;
    else if (busy) wd <= wd + 1'b1;
  assign abort = busy && !done_valid && wd == 32'(TIMEOUT_CYCLES - 1);
`else
  // no watchdog: a negative limit is impossible, so this never fires
  assign abort = TIMEOUT_CYCLES < 0;
`endif
  vta_host_req_port #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) u_port (
    .clock(clock), .reset(reset), .issue(issue), .abort(abort), .issue_op(iss_op),
    .issue_addr(iss_addr), .issue_value(iss_value), .req_deq(req_deq), .resp_valid(resp_valid),
    .req_valid(req_valid), .req_opcode(req_opcode), .req_addr(req_addr), .req_value(req_value),
    .accepted(accepted), .resp_ok(resp_ok)
  );
endmodule

// File: tb/tb_vta_host_launch_seq.sv
// tb_vta_host_launch_seq: directed launches against a simple register-slave model
module tb_vta_host_launch_seq;
  localparam int NA = 4, DB = 32, PG = 8;
`ifdef VTA_HOST_LAUNCH_SEQ_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif
  typedef struct {logic op; logic [7:0] addr; logic [31:0] val; int c;} txn_t;
  logic clock = 0, reset = 1, cmd_valid = 0, req_deq = 1, resp_valid = 0;
  logic cmd_ready, req_valid, req_opcode, busy, done_valid, done_timeout;
  logic [NA*DB-1:0] cmd_args = '0;
  logic [7:0] req_addr;
  logic [31:0] req_value, done_cycles, resp_bits = '0;
  int total = 0, bad = 0, cyc = 0, n_done = 0, d_cyc = 0, acc_cyc = 0, stall_left = 0;
  logic [31:0] d_cycles, cyc_val = 32'h1234;
  logic d_to;
  logic [31:0] ctrl_q[$];
  txn_t log_q[$];
  logic [127:0] a1 = {32'h44, 32'h33, 32'h22, 32'h11};
  logic [127:0] a2 = {32'hDD, 32'hCC, 32'hBB, 32'hAA};
  logic [127:0] a3 = {32'h4, 32'h3, 32'h2, 32'h1};
  int n, rd_c[$];

  vta_host_launch_seq #(.ADDR_BITS(8), .DATA_BITS(DB), .NUM_ARGS(NA), .POLL_GAP(PG), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_args(cmd_args),
    .req_valid(req_valid), .req_opcode(req_opcode), .req_addr(req_addr), .req_value(req_value),
    .req_deq(req_deq), .resp_valid(resp_valid), .resp_bits(resp_bits), .busy(busy),
    .done_valid(done_valid), .done_cycles(done_cycles), .done_timeout(done_timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic op, input logic [7:0] a, input logic [31:0] v);
    return {23'b0, op, a, v};
  endfunction

  // one clock; slave answers each accepted read with data in the following cycle
  task automatic tick;
    bit acc;
    logic op;
    logic [7:0] ad;
    txn_t t;
    acc = req_valid && req_deq;
    op = req_opcode;
    ad = req_addr;
    if (acc) begin
      t.op = req_opcode; t.addr = req_addr; t.val = req_value; t.c = cyc;
      log_q.push_back(t);
    end
    @(posedge clock);
    #1;
    cyc++;
    resp_valid = 0;
    resp_bits = '0;
    if (acc && !op) begin
      resp_valid = 1;
      resp_bits = ad != 8'h00 ? cyc_val : ctrl_q.size() > 0 ? ctrl_q.pop_front() : 32'h0;
    end
    if (done_valid) begin
      n_done++; d_cyc = cyc; d_cycles = done_cycles; d_to = done_timeout;
    end
    req_deq = 1;
    if (stall_left > 0 && req_valid && req_addr == 8'h0C) begin
      req_deq = 0;
      stall_left--;
      check("stall_hold", {req_valid, req_opcode, req_addr, req_value}, {1'b1, 1'b1, 8'h0C, 32'h22});
    end
  endtask

  task automatic launch(input logic [127:0] a, input bit hold);
    cmd_args = a;
    cmd_valid = 1;
    for (int k = 0; k < 50 && !cmd_ready; k++) tick;
    acc_cyc = cyc;
    tick;
    if (!hold) cmd_valid = 0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = n_done;
    for (int k = 0; k < budget && n_done == start; k++) tick;
    check("done_seen", 64'(n_done - start), 1);
  endtask

  task automatic check_launch(input string tag, input logic [127:0] a);
    logic [63:0] exp [7];
    for (int i = 0; i < 4; i++) exp[i] = pk(1, 8'(8 + 4 * i), a[i*32 +: 32]);
    exp[4] = pk(1, 8'h00, 1);
    exp[5] = pk(0, 8'h00, 0);
    exp[6] = pk(0, 8'h04, 0);
    check({tag, "_count"}, 64'(log_q.size()), 7);
    for (int i = 0; i < 7 && i < log_q.size(); i++)
      check($sformatf("%s_txn%0d", tag, i), pk(log_q[i].op, log_q[i].addr, log_q[i].val), exp[i]);
  endtask

  function automatic bit has_ctrl_rd();
    foreach (log_q[i]) if (!log_q[i].op && log_q[i].addr == 8'h00) return 1;
    return 0;
  endfunction

  initial begin
    repeat (2) tick;
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_req", {req_valid, req_opcode, req_addr, req_value}, 0);
    check("rst_done", {done_valid, done_timeout, done_cycles}, 0);
    reset = 0;
    tick;
    // single poll, done immediately
    log_q.delete(); ctrl_q = {32'h2};
    launch(a1, 0);
    wait_done(100);
    check_launch("t1", a1);
    check("t1_lat", 64'(d_cyc - acc_cyc), 10);
    check("t1_cycles", d_cycles, 32'h1234);
    check("t1_to", d_to, 0);
    tick;
    check("t1_pulse", done_valid, 0);
    check("t1_ready", cmd_ready, 1);
    check("t1_hold", done_cycles, 32'h1234);
    // two failed polls, POLL_GAP idle cycles after each response
    log_q.delete(); ctrl_q = {32'h0, 32'h0, 32'h2};
    launch(a1, 0);
    wait_done(200);
    rd_c.delete();
    foreach (log_q[i]) if (!log_q[i].op && log_q[i].addr == 8'h00) rd_c.push_back(log_q[i].c);
    check("t2_polls", 64'(rd_c.size()), 3);
    for (int i = 1; i < rd_c.size(); i++) check("t2_gap", 64'(rd_c[i] - rd_c[i-1]), PG + 2);
    check("t2_lat", 64'(d_cyc - acc_cyc), 30);
    check("t2_cycles", d_cycles, 32'h1234);
    tick;
    // ARG1 held off for 5 cycles
    log_q.delete(); ctrl_q = {32'h2}; stall_left = 5;
    launch(a1, 0);
    wait_done(100);
    check_launch("t3", a1);
    check("t3_stalls", 64'(stall_left), 0);
    check("t3_lat", 64'(d_cyc - acc_cyc), 15);
    tick;
    // cmd_valid held and a spurious response during WR_ARG
    log_q.delete(); ctrl_q = {32'h2}; n = n_done;
    launch(a2, 1);
    resp_valid = 1; resp_bits = 32'h2;
    wait_done(100);
    cmd_valid = 0;
    repeat (3) tick;
    check_launch("t5", a2);
    check("t5_lat", 64'(d_cyc - acc_cyc), 10);
    check("t5_dones", 64'(n_done - n), 1);
    check("t5_idle", busy, 0);
    // reset while waiting in GAP
    log_q.delete(); ctrl_q.delete();
    launch(a1, 0);
    for (int k = 0; k < 40 && !has_ctrl_rd(); k++) tick;
    repeat (3) tick;
    check("t4_in_gap", {busy, req_valid}, 2'b10);
    reset = 1;
    tick;
    check("t4_rst_ready", {cmd_ready, busy}, 2'b10);
    check("t4_rst_req", {req_valid, req_opcode, req_addr, req_value}, 0);
    check("t4_rst_done", {done_valid, done_timeout, done_cycles}, 0);
    reset = 0;
    resp_valid = 1; resp_bits = 32'h2;
    tick;
    check("t4_stale", {busy, req_valid}, 0);
    log_q.delete(); ctrl_q = {32'h2}; cyc_val = 32'h55AA;
    launch(a3, 0);
    wait_done(100);
    check_launch("t4", a3);
    check("t4_cycles", d_cycles, 32'h55AA);
    tick;
`ifdef VTA_HOST_LAUNCH_SEQ_TIMEOUT_EN
    // CTRL never reports done; watchdog forces DONE
    log_q.delete(); ctrl_q.delete();
    launch(a1, 0);
    wait_done(300);
    check("t6_to", d_to, 1);
    check("t6_cycles", d_cycles, 0);
    check("t6_lat", 64'(d_cyc - acc_cyc), TO + 1);
    check("t6_req", req_valid, 0);
    tick;
    check("t6_ready", {cmd_ready, done_valid, done_timeout}, 3'b100);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vta_host_launch_seq.md
Name: vta_host_launch_seq

Overview:
- Hardware launch sequencer that drives the VTA host register-access port (valid/opcode/addr/value request, deq accept, resp_valid/resp_bits read return) in place of software.
- On one command it writes NUM_ARGS argument registers, writes the start bit, polls the control register until done, then reads the cycle counter.
- Sits between a test/offload front-end and the VTA control-register slave, on the same bus the host DPI bridge drives.

Parameters:
- ADDR_BITS, 8, register address width
- DATA_BITS, 32, register data width
- NUM_ARGS, 4, argument registers written per launch (1..16)
- POLL_GAP, 8, idle cycles between control-register polls (>=1)
- TIMEOUT_CYCLES, 65535, watchdog limit; used only with the optional feature

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  launch request
- cmd_ready  out  1  high only in IDLE
- cmd_args  in  NUM_ARGS*DATA_BITS  argument values; arg i in bits [i*DATA_BITS +: DATA_BITS]
- req_valid  out  1  register request valid
- req_opcode  out  1  1=write, 0=read
- req_addr  out  ADDR_BITS  register byte address
- req_value  out  DATA_BITS  write data (0 on reads)
- req_deq  in  1  slave accepts the request this cycle
- resp_valid  in  1  read data valid
- resp_bits  in  DATA_BITS  read data
- busy  out  1  high when not IDLE
- done_valid  out  1  one-cycle completion pulse
- done_cycles  out  DATA_BITS  CYCLES register value; held until the next done_valid
- done_timeout  out  1  qualifies done_valid; always 0 without the optional feature

Behaviour:
- Register map:
  - CTRL=0x00: bit0 start, bit1 done.
  - CYCLES=0x04.
  - ARG i = 0x08+4*i.
- Reset: all outputs 0 except cmd_ready=1; FSM goes to IDLE and arg latch/counters clear. A reset mid-operation abandons the transaction with no drain, and a later resp_valid is ignored.
- Request handshake:
  - req_valid, once asserted, holds addr/opcode/value stable until the cycle req_deq=1.
  - The transfer completes on that edge, and req_valid drops the next cycle unless the next request issues back-to-back (allowed for writes).
- FSM:
  - IDLE: when cmd_valid and cmd_ready, latch cmd_args, set arg_idx=0, go to WR_ARG.
  - WR_ARG: write ARG arg_idx. On deq, increment arg_idx; after the last arg go to WR_START.
  - WR_START: write CTRL=0x1. On deq, go to RD_CTRL.
  - RD_CTRL: read CTRL. On deq, go to WAIT_CTRL.
  - WAIT_CTRL: on resp_valid, if resp_bits[1]=1 go to RD_CYC; else load the gap counter with POLL_GAP and go to GAP.
  - GAP: count down to 0, then go to RD_CTRL.
  - RD_CYC: read CYCLES. On deq, go to WAIT_CYC.
  - WAIT_CYC: on resp_valid, capture done_cycles and go to DONE.
  - DONE: done_valid=1 for exactly one cycle, then IDLE (cmd_ready rises in the IDLE cycle).
- Latency: with req_deq tied high and a 1-cycle read return, cmd accept to done_valid = NUM_ARGS+1 write cycles + 2 per poll + POLL_GAP per failed poll + 2 + 1.
- Boundary rules:
  - resp_valid outside WAIT_* is ignored.
  - req_deq while req_valid=0 is ignored.
  - A resp_valid in the same cycle as req_deq of the read is not accepted; the response must come at least one cycle later.
  - cmd_valid while busy is not accepted.
  - arg_idx width is clog2(NUM_ARGS)+1 so it does not wrap.
  - NUM_ARGS=1 is legal.

Optional Feature:
- Macro: VTA_HOST_LAUNCH_SEQ_TIMEOUT_EN.
- With the macro: a 32-bit watchdog clears on cmd accept and counts every busy cycle. On reaching TIMEOUT_CYCLES in any state before DONE, the FSM jumps to DONE with done_timeout=1, done_cycles=0 and req_valid dropped; any outstanding response is ignored.
- Without the macro: no watchdog, done_timeout tied 0, the FSM polls forever.

Decomposition:
- Package vta_host_pkg:
  - register address constants (CTRL/CYCLES/ARG_BASE/ARG_STRIDE)
  - CTRL bit positions
  - opcode constants (OP_RD=0, OP_WR=1)
  - FSM state enum
- One natural sub-module: vta_host_req_port, which owns the req_valid/addr/opcode/value registers, hold-until-deq logic and outstanding-read tracking. The sequencer FSM drives it with issue/accepted/resp strobes.

Test Plan:
- NUM_ARGS=4, args {0x11,0x22,0x33,0x44}, req_deq=1, CTRL read returns 0x2 first poll, CYCLES=0x1234 -> writes (0x08,0x11),(0x0C,0x22),(0x10,0x33),(0x14,0x44),(0x00,0x1); reads 0x00, 0x04; done_valid one cycle, done_cycles=0x1234, done_timeout=0.
- Same launch, CTRL returns 0x0 twice then 0x2 -> exactly 3 CTRL reads, each later read issued POLL_GAP=8 cycles after the previous response.
- req_deq low 5 cycles on ARG1 write -> req_valid/addr=0x0C/value=0x22 stable all 5 cycles; no ARG2 before deq.
- Reset asserted while in GAP, then new cmd with args {1,2,3,4} -> all outputs reset next cycle; stale resp_valid ignored; new launch starts at ARG0.
- cmd_valid held high through a launch and a spurious resp_valid in WR_ARG -> only one command accepted, no state change from the spurious response.
- With VTA_HOST_LAUNCH_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, CTRL never done -> done_valid with done_timeout=1, done_cycles=0 when the watchdog reaches 100; cmd_ready=1 the following cycle.
